// File: rtl/mem_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_loader_if : core-side memory bus (address, store, read data)   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mem_loader_if;
  logic [7:0] Adr;
  logic       MemWrite;
  logic [7:0] WriteData;
  logic [6:0] MemData1;
  logic [7:0] MemData2;

  modport master (
    output Adr,
    output MemWrite,
    output WriteData,
    input  MemData1,
    input  MemData2
  );

  modport slave (
    input  Adr,
    input  MemWrite,
    input  WriteData,
    output MemData1,
    output MemData2
  );
endinterface
`default_nettype wire

// File: rtl/mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_loader : 256x15 HMMM memory with serial program-load port      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 23
) (
  input  wire logic       ph1,
  input  wire logic       reset,
  input  wire logic       load_en,
  input  wire logic       sclk,
  input  wire logic       sdi,
  input  wire logic       start,
  mem_loader_if.slave     bus,
  output logic            cpu_reset,
  output logic            busy,
  output logic            frame_err,
  output logic [8:0]      frames
);

  localparam int ADDR_W = 8;
  localparam int DATA_W = 15;
  localparam int CNT_W  = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] C_FRAME_LAST = CNT_W'(FRAME_BITS);
  localparam logic [8:0]       C_FRAMES_MAX = 9'h1FF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [SYNC_STAGES-1:0] r_le_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_sclk_d;

  logic [1:0]             r_state;
  logic                   r_cpu_reset;
  logic                   r_frame_err;
  logic [8:0]             r_frames;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [CNT_W-1:0]       r_bitcnt;

  logic [DATA_W-1:0]      r_mem [0:(1<<ADDR_W)-1];

  logic                   w_le_s;
  logic                   w_sdi_s;
  logic                   w_sclk_edge;
  logic                   w_load_wr;
  logic                   w_core_wr;
  logic [ADDR_W-1:0]      w_load_addr;
  logic [DATA_W-1:0]      w_load_data;
  logic [DATA_W-1:0]      w_rd_word;

  // All three serial inputs share the same depth so sdi lines up with the sclk edge.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_le_sync   <= '0;
      r_sclk_sync <= '0;
      r_sdi_sync  <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_le_sync   <= {r_le_sync[SYNC_STAGES-2:0],   load_en};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0],  sdi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_le_s      = r_le_sync[SYNC_STAGES-1];
  assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
  assign w_sclk_edge = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;

  assign w_load_addr = r_shift[FRAME_BITS-1:DATA_W];
  assign w_load_data = r_shift[DATA_W-1:0];
  assign w_load_wr   = (r_state == ST_LOAD) && w_le_s && (r_bitcnt == C_FRAME_LAST);
  assign w_core_wr   = (r_state == ST_RUN) && bus.MemWrite;

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cpu_reset <= 1'b1;
      r_frame_err <= 1'b0;
      r_frames    <= '0;
      r_shift     <= '0;
      r_bitcnt    <= '0;
    end else begin
      // Core leaves reset only after a full cycle spent in RUN.
      r_cpu_reset <= !((r_state == ST_RUN) && !w_le_s);
      case (r_state)
        ST_IDLE: begin
          if (w_le_s) begin
            r_state     <= ST_LOAD;
            r_frames    <= '0;
            r_frame_err <= 1'b0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
          end else if (start) begin
            r_state <= ST_RUN;
          end
        end
        ST_LOAD: begin
          if (!w_le_s) begin
            r_state <= ST_IDLE;
            if (r_bitcnt != '0) begin
              r_frame_err <= 1'b1;
            end
            r_bitcnt <= '0;
          end else if (r_bitcnt == C_FRAME_LAST) begin
            r_bitcnt <= '0;
            if (r_frames != C_FRAMES_MAX) begin
              r_frames <= r_frames + 9'd1;
            end
          end else if (w_sclk_edge) begin
            r_shift  <= {r_shift[FRAME_BITS-2:0], w_sdi_s};
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (w_le_s) begin
            r_state     <= ST_LOAD;
            r_frames    <= '0;
            r_frame_err <= 1'b0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory is deliberately not reset so a loaded program survives a reset.
  always_ff @(posedge ph1) begin
    if (w_load_wr) begin
      r_mem[w_load_addr] <= w_load_data;
    end else if (w_core_wr) begin
      r_mem[bus.Adr][7:0] <= bus.WriteData;
    end
  end

  assign w_rd_word    = r_mem[bus.Adr];
  assign bus.MemData1 = w_rd_word[14:8];
  assign bus.MemData2 = w_rd_word[7:0];

  assign cpu_reset = r_cpu_reset;
  assign busy      = (r_state == ST_LOAD);
  assign frame_err = r_frame_err;
  assign frames    = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_loader : randomized directed bench against a memory model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mem_loader;
  localparam int SYNC_STAGES = 2;

  logic       ph1 = 1'b0;
  logic       reset = 1'b0;
  logic       load_en = 1'b0;
  logic       sclk = 1'b0;
  logic       sdi = 1'b0;
  logic       start = 1'b0;
  logic       cpu_reset;
  logic       busy;
  logic       frame_err;
  logic [8:0] frames;

  mem_loader_if bus();

  always #5 ph1 = ~ph1;

  mem_loader #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BITS(23)) dut (
    .ph1       (ph1),
    .reset     (reset),
    .load_en   (load_en),
    .sclk      (sclk),
    .sdi       (sdi),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .frame_err (frame_err),
    .frames    (frames)
  );

  logic [14:0] mm [256];
  bit          known [256];
  int          kaddr [$];
  int          exp_frames = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    repeat (2) tick();
    sclk = 1'b1;
    repeat (3) tick();
    sclk = 1'b0;
    tick();
  endtask

  task automatic load_frame(input logic [7:0] a, input logic [14:0] d);
    logic [22:0] f;
    f = {a, d};
    for (int i = 22; i >= 0; i--) send_bit(f[i]);
    repeat (2) tick();
    if (!known[a]) kaddr.push_back(int'(a));
    mm[a]    = d;
    known[a] = 1'b1;
    exp_frames = (exp_frames < 511) ? exp_frames + 1 : 511;
    check("frames_count", 16'(frames), 16'(exp_frames));
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 256; a++) begin
      if (known[a]) begin
        bus.Adr = a[7:0];
        #1;
        check($sformatf("%s_hi[%0h]", tag, a), 16'(bus.MemData1), 16'(mm[a][14:8]));
        check($sformatf("%s_lo[%0h]", tag, a), 16'(bus.MemData2), 16'(mm[a][7:0]));
      end
    end
  endtask

  task automatic open_session();
    load_en = 1'b1;
    repeat (SYNC_STAGES + 1) tick();
    exp_frames = 0;
    check("open_cpu_reset", 16'(cpu_reset), 16'd1);
    check("open_busy", 16'(busy), 16'd1);
    check("open_frames", 16'(frames), 16'd0);
    check("open_frame_err", 16'(frame_err), 16'd0);
  endtask

  task automatic close_session(input logic partial);
    load_en = 1'b0;
    repeat (SYNC_STAGES + 2) tick();
    check("close_busy", 16'(busy), 16'd0);
    check("close_cpu_reset", 16'(cpu_reset), 16'd1);
    check("close_frame_err", 16'(frame_err), 16'(partial));
    check("close_frames", 16'(frames), 16'(exp_frames));
  endtask

  task automatic go_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("run_cpu_reset", 16'(cpu_reset), 16'd0);
  endtask

  task automatic core_store(input logic [7:0] a, input logic [7:0] wd, input logic in_run);
    bus.Adr       = a;
    bus.WriteData = wd;
    bus.MemWrite  = 1'b1;
    tick();
    bus.MemWrite  = 1'b0;
    if (in_run && known[a]) mm[a][7:0] = wd;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a;
    bus.Adr       = '0;
    bus.MemWrite  = 1'b0;
    bus.WriteData = '0;

    repeat (3) tick();
    check("rst_cpu_reset", 16'(cpu_reset), 16'd1);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_frames", 16'(frames), 16'd0);
    check("rst_frame_err", 16'(frame_err), 16'd0);
    reset = 1'b1;
    repeat (20) tick();
    check("idle_cpu_reset", 16'(cpu_reset), 16'd1);
    check("idle_busy", 16'(busy), 16'd0);
    check("idle_frames", 16'(frames), 16'd0);
    go_run();

    // Session from RUN: known frame, random frames, then the store target.
    open_session();
    load_frame(8'h05, 15'h1A3C);
    for (int i = 0; i < 6; i++) begin
      do a = 8'($urandom_range(0, 255)); while (a == 8'h05 || a == 8'h80);
      load_frame(a, 15'($urandom));
    end
    load_frame(8'h80, 15'h7F00);
    close_session(1'b0);
    bus.Adr = 8'h05;
    #1;
    check("mem5_hi", 16'(bus.MemData1), 16'h001A);
    check("mem5_lo", 16'(bus.MemData2), 16'h003C);
    check_mem("load1");

    // Full frame followed by a truncated one.
    open_session();
    do a = 8'($urandom_range(0, 255)); while (a == 8'h05 || a == 8'h80);
    load_frame(a, 15'($urandom));
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
    close_session(1'b1);
    check_mem("partial");

    core_store(8'h80, 8'h11, 1'b0);
    check_mem("idle_store");

    go_run();
    check("run_frame_err_sticky", 16'(frame_err), 16'd1);
    core_store(8'h80, 8'hAA, 1'b1);
    check("store80_hi", 16'(bus.MemData1), 16'h007F);
    check("store80_lo", 16'(bus.MemData2), 16'h00AA);
    for (int i = 0; i < 5; i++) begin
      a = 8'(kaddr[$urandom_range(0, kaddr.size() - 1)]);
      core_store(a, 8'($urandom), 1'b1);
    end
    check_mem("run_store");

    open_session();
    core_store(8'h80, 8'h55, 1'b0);
    check_mem("load_store");

    // Reset in the middle of a frame aimed at 0x80.
    for (int i = 22; i >= 11; i--) begin
      logic [22:0] f;
      f = {8'h80, 15'h1234};
      send_bit(f[i]);
    end
    reset = 1'b0;
    repeat (2) tick();
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_cpu_reset", 16'(cpu_reset), 16'd1);
    check("midrst_frames", 16'(frames), 16'd0);
    check("midrst_frame_err", 16'(frame_err), 16'd0);
    load_en = 1'b0;
    reset = 1'b1;
    repeat (4) tick();
    check("postrst_busy", 16'(busy), 16'd0);
    check_mem("midrst");

    open_session();
    load_frame(8'h80, 15'($urandom));
    close_session(1'b0);
    check_mem("reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
